// File: rtl/vfe_pkg.sv
// Shared definitions for the variable flip engine: FSM states and width helpers.
`default_nettype none

package vfe_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DECIDE  = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  function automatic int kb_width(input int k);
    return (k < 2) ? 1 : $clog2(k);
  endfunction

  function automatic int mcb_width(input int mc);
    return $clog2(mc + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/masked_popcount.sv
// Exact population count of (bits & mask); the result width holds MC without saturation.
`default_nettype none

module masked_popcount
  import vfe_pkg::*;
#(
  parameter int MC = 20
) (
  input  logic [MC-1:0]              bits,
  input  logic [MC-1:0]              mask,
  output logic [mcb_width(MC)-1:0]   count
);

  localparam int MCB = mcb_width(MC);

  always_comb begin
    count = '0;
    for (int i = 0; i < MC; i++) begin
      count = count + MCB'(bits[i] & mask[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/variable_flip_engine.sv
// Collects up to K candidate literals of a clause and picks the variable to flip
// (freebie, WalkSAT noise step, or greedy minimum break count).
`default_nettype none

module variable_flip_engine
  import vfe_pkg::*;
#(
  parameter int          K  = 3,
  parameter int          MC = 20,
  parameter logic [31:0] P  = 32'h6E147AE0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       lit_valid_i,
  output logic                       lit_ready_o,
  input  logic [MC-1:0]              clause_broken_i,
  input  logic [MC-1:0]              mask_bits_i,
  input  logic                       lit_enable_i,
  input  logic                       lit_last_i,
  input  logic                       mode_i,
  input  logic [31:0]                random_i,
  output logic                       sel_valid_o,
  input  logic                       sel_ready_i,
  output logic [kb_width(K)-1:0]     selected_o,
  output logic [mcb_width(MC)-1:0]   break_value_o,
  output logic [MC-1:0]              clause_broken_bits_o,
  output logic                       no_candidate_o
);

  localparam int KB  = kb_width(K);
  localparam int MCB = mcb_width(MC);

  state_t          state;
  logic [KB-1:0]   cnt;
  logic [MCB-1:0]  slot_brk  [K];
  logic [MC-1:0]   slot_bits [K];
  logic            slot_en   [K];

  logic [MCB-1:0]  beat_brk;
  logic            beat_fire;

  masked_popcount #(.MC(MC)) u_popcount (
    .bits  (clause_broken_i),
    .mask  (mask_bits_i),
    .count (beat_brk)
  );

  assign lit_ready_o = (state == COLLECT);
  assign beat_fire   = lit_valid_i & lit_ready_o;

  // Selection network, consumed only while in DECIDE.
  logic [KB-1:0]   start;
  logic [KB-1:0]   idx;
  logic [KB-1:0]   free_idx;
  logic [KB-1:0]   noise_idx;
  logic [KB-1:0]   greedy_idx;
  logic [KB-1:0]   pick;
  logic            free_found;
  logic            any_found;
  logic [MCB-1:0]  min_brk;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    noise_idx  = '0;
    greedy_idx = '0;
    any_found  = 1'b0;
    min_brk    = '0;
    idx        = '0;
    start      = KB'({16'd0, random_i[31:16]} % K);
    for (int i = K - 1; i >= 0; i--) begin
      if (slot_en[i] && slot_brk[i] == '0) begin
        free_found = 1'b1;
        free_idx   = KB'(i);
      end
    end
    // Descending offsets so the nearest eligible slot after start wins.
    for (int o = K - 1; o >= 0; o--) begin
      idx = KB'((int'(start) + o) % K);
      if (slot_en[idx]) noise_idx = idx;
    end
    for (int i = 0; i < K; i++) begin
      if (slot_en[i] && (!any_found || slot_brk[i] < min_brk)) begin
        any_found  = 1'b1;
        greedy_idx = KB'(i);
        min_brk    = slot_brk[i];
      end
    end
    if (free_found)                   pick = free_idx;
    else if (!mode_i && random_i < P) pick = noise_idx;
    else                              pick = greedy_idx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= COLLECT;
      cnt                  <= '0;
      sel_valid_o          <= 1'b0;
      selected_o           <= '0;
      break_value_o        <= '0;
      clause_broken_bits_o <= '0;
      no_candidate_o       <= 1'b0;
      for (int i = 0; i < K; i++) begin
        slot_brk[i]  <= '0;
        slot_bits[i] <= '0;
        slot_en[i]   <= 1'b0;
      end
    end else begin
      case (state)
        COLLECT: begin
          if (beat_fire) begin
            slot_brk[cnt]  <= beat_brk;
            slot_bits[cnt] <= clause_broken_i & mask_bits_i;
            slot_en[cnt]   <= lit_enable_i;
            cnt            <= cnt + 1'b1;
            if (lit_last_i || cnt == KB'(K - 1)) state <= DECIDE;
          end
        end
        DECIDE: begin
          state       <= OUTPUT;
          sel_valid_o <= 1'b1;
          if (any_found) begin
            no_candidate_o       <= 1'b0;
            selected_o           <= pick;
            break_value_o        <= slot_brk[pick];
            clause_broken_bits_o <= slot_bits[pick];
          end else begin
            no_candidate_o       <= 1'b1;
            selected_o           <= '0;
            break_value_o        <= '0;
            clause_broken_bits_o <= '0;
          end
        end
        OUTPUT: begin
          if (sel_ready_i) begin
            state       <= COLLECT;
            sel_valid_o <= 1'b0;
            cnt         <= '0;
            for (int i = 0; i < K; i++) slot_en[i] <= 1'b0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_variable_flip_engine.sv
// Directed self-checking bench for variable_flip_engine at default parameters.
`default_nettype none

module tb_variable_flip_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        lit_valid;
  logic        lit_ready;
  logic [19:0] clause_broken;
  logic [19:0] mask_bits;
  logic        lit_enable;
  logic        lit_last;
  logic        mode;
  logic [31:0] random;
  logic        sel_valid;
  logic        sel_ready;
  logic [1:0]  selected;
  logic [4:0]  break_value;
  logic [19:0] bits_out;
  logic        no_candidate;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  variable_flip_engine dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .lit_valid_i          (lit_valid),
    .lit_ready_o          (lit_ready),
    .clause_broken_i      (clause_broken),
    .mask_bits_i          (mask_bits),
    .lit_enable_i         (lit_enable),
    .lit_last_i           (lit_last),
    .mode_i               (mode),
    .random_i             (random),
    .sel_valid_o          (sel_valid),
    .sel_ready_i          (sel_ready),
    .selected_o           (selected),
    .break_value_o        (break_value),
    .clause_broken_bits_o (bits_out),
    .no_candidate_o       (no_candidate)
  );

  function automatic logic [19:0] mask_of(input int b);
    return 20'((32'd1 << b) - 32'd1);
  endfunction

  // Broken flags all set; the mask selects exactly b of them.
  task automatic beat(input int b, input logic en, input logic last);
    clause_broken = 20'hFFFFF;
    mask_bits     = mask_of(b);
    lit_enable    = en;
    lit_last      = last;
    lit_valid     = 1'b1;
    @(posedge clk); #1;
    lit_valid     = 1'b0;
    lit_last      = 1'b0;
  endtask

  task automatic wait_valid(output logic got);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (sel_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic take_result;
    sel_ready = 1'b1;
    @(posedge clk); #1;
    sel_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; lit_valid = 1'b0; sel_ready = 1'b0; lit_enable = 1'b0;
    lit_last = 1'b0; mode = 1'b0; random = '0; clause_broken = '0; mask_bits = '0;
    #2;
    total_cnt++; if (sel_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", sel_valid); else pass_cnt++;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    total_cnt++; if (selected !== 2'd0) $display("FAIL reset_sel got=%0d exp=0", selected); else pass_cnt++;
    total_cnt++; if (break_value !== 5'd0) $display("FAIL reset_brk got=%0d exp=0", break_value); else pass_cnt++;
    total_cnt++; if (bits_out !== 20'd0) $display("FAIL reset_bits got=%h exp=0", bits_out); else pass_cnt++;
    total_cnt++; if (no_candidate !== 1'b0) $display("FAIL reset_nc got=%0b exp=0", no_candidate); else pass_cnt++;
    total_cnt++; if (lit_ready !== 1'b1) $display("FAIL reset_ready got=%0b exp=1", lit_ready); else pass_cnt++;
  endtask

  task automatic test_freebie;
    logic got;
    mode = 1'b0; random = 32'h0;
    beat(2, 1'b1, 1'b0); beat(0, 1'b1, 1'b0); beat(1, 1'b1, 1'b0);
    total_cnt++; if (sel_valid !== 1'b0) $display("FAIL decide_not_valid got=%0b exp=0", sel_valid); else pass_cnt++;
    wait_valid(got);
    total_cnt++; if (got !== 1'b1 || selected !== 2'd1) $display("FAIL freebie_sel got=%0d exp=1 valid=%0b", selected, got); else pass_cnt++;
    total_cnt++; if (break_value !== 5'd0) $display("FAIL freebie_brk got=%0d exp=0", break_value); else pass_cnt++;
    total_cnt++; if (no_candidate !== 1'b0) $display("FAIL freebie_nc got=%0b exp=0", no_candidate); else pass_cnt++;
    total_cnt++; if (bits_out !== 20'd0) $display("FAIL freebie_bits got=%h exp=0", bits_out); else pass_cnt++;
    take_result;
  endtask

  task automatic test_greedy;
    logic got;
    mode = 1'b0; random = 32'hFFFFFFFF;
    beat(3, 1'b1, 1'b0); beat(1, 1'b1, 1'b0); beat(1, 1'b1, 1'b0);
    wait_valid(got);
    total_cnt++; if (got !== 1'b1 || selected !== 2'd1) $display("FAIL greedy_tie_sel got=%0d exp=1 valid=%0b", selected, got); else pass_cnt++;
    total_cnt++; if (break_value !== 5'd1) $display("FAIL greedy_tie_brk got=%0d exp=1", break_value); else pass_cnt++;
    total_cnt++; if (bits_out !== mask_of(1)) $display("FAIL greedy_bits got=%h exp=%h", bits_out, mask_of(1)); else pass_cnt++;
    take_result;
    beat(3, 1'b1, 1'b0); beat(1, 1'b0, 1'b0); beat(1, 1'b1, 1'b0);
    wait_valid(got);
    total_cnt++; if (got !== 1'b1 || selected !== 2'd2) $display("FAIL greedy_dis_sel got=%0d exp=2 valid=%0b", selected, got); else pass_cnt++;
    total_cnt++; if (break_value !== 5'd1) $display("FAIL greedy_dis_brk got=%0d exp=1", break_value); else pass_cnt++;
    take_result;
  endtask

  task automatic test_noise;
    logic got;
    mode = 1'b0; random = 32'h00020000;
    beat(2, 1'b1, 1'b0); beat(3, 1'b1, 1'b0); beat(4, 1'b1, 1'b0);
    wait_valid(got);
    total_cnt++; if (got !== 1'b1 || selected !== 2'd2) $display("FAIL noise_sel got=%0d exp=2 valid=%0b", selected, got); else pass_cnt++;
    total_cnt++; if (break_value !== 5'd4) $display("FAIL noise_brk got=%0d exp=4", break_value); else pass_cnt++;
    take_result;
    mode = 1'b1;
    beat(2, 1'b1, 1'b0); beat(3, 1'b1, 1'b0); beat(4, 1'b1, 1'b0);
    wait_valid(got);
    total_cnt++; if (got !== 1'b1 || selected !== 2'd0) $display("FAIL mode1_sel got=%0d exp=0 valid=%0b", selected, got); else pass_cnt++;
    total_cnt++; if (break_value !== 5'd2) $display("FAIL mode1_brk got=%0d exp=2", break_value); else pass_cnt++;
    take_result;
    // Start at slot 2 which is disabled: the search wraps to slot 0, not the greedy slot 1.
    mode = 1'b0;
    beat(4, 1'b1, 1'b0); beat(3, 1'b1, 1'b0); beat(2, 1'b0, 1'b0);
    wait_valid(got);
    total_cnt++; if (got !== 1'b1 || selected !== 2'd0) $display("FAIL noise_wrap_sel got=%0d exp=0 valid=%0b", selected, got); else pass_cnt++;
    total_cnt++; if (break_value !== 5'd4) $display("FAIL noise_wrap_brk got=%0d exp=4", break_value); else pass_cnt++;
    take_result;
  endtask

  task automatic test_short_and_empty;
    logic got;
    mode = 1'b0; random = 32'hFFFFFFFF;
    beat(5, 1'b1, 1'b0); beat(4, 1'b1, 1'b1);
    wait_valid(got);
    total_cnt++; if (got !== 1'b1 || selected !== 2'd1) $display("FAIL short_sel got=%0d exp=1 valid=%0b", selected, got); else pass_cnt++;
    total_cnt++; if (break_value !== 5'd4) $display("FAIL short_brk got=%0d exp=4", break_value); else pass_cnt++;
    take_result;
    beat(1, 1'b0, 1'b0); beat(0, 1'b0, 1'b0); beat(2, 1'b0, 1'b0);
    wait_valid(got);
    total_cnt++; if (got !== 1'b1 || no_candidate !== 1'b1) $display("FAIL empty_nc got=%0b exp=1 valid=%0b", no_candidate, got); else pass_cnt++;
    total_cnt++; if (selected !== 2'd0 || break_value !== 5'd0 || bits_out !== 20'd0)
      $display("FAIL empty_zero got sel=%0d brk=%0d bits=%h exp all 0", selected, break_value, bits_out); else pass_cnt++;
    take_result;
  endtask

  task automatic test_backpressure;
    logic got;
    mode = 1'b0; random = 32'hFFFFFFFF;
    beat(1, 1'b1, 1'b0); beat(2, 1'b1, 1'b0); beat(3, 1'b1, 1'b0);
    wait_valid(got);
    total_cnt++; if (got !== 1'b1 || selected !== 2'd0) $display("FAIL bp_sel got=%0d exp=0 valid=%0b", selected, got); else pass_cnt++;
    clause_broken = 20'hFFFFF; mask_bits = 20'd0; lit_enable = 1'b1; lit_last = 1'b1; lit_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (sel_valid !== 1'b1 || lit_ready !== 1'b0 || selected !== 2'd0 || break_value !== 5'd1 || bits_out !== mask_of(1))
        $display("FAIL bp_hold cyc=%0d got valid=%0b ready=%0b sel=%0d brk=%0d exp 1/0/0/1", c, sel_valid, lit_ready, selected, break_value);
      else pass_cnt++;
    end
    lit_valid = 1'b0; lit_last = 1'b0;
    take_result;
    beat(3, 1'b1, 1'b1);
    wait_valid(got);
    total_cnt++; if (got !== 1'b1 || selected !== 2'd0 || break_value !== 5'd3)
      $display("FAIL bp_no_store got sel=%0d brk=%0d exp sel=0 brk=3 valid=%0b", selected, break_value, got); else pass_cnt++;
    take_result;
  endtask

  task automatic test_reset_mid;
    logic got;
    mode = 1'b1; random = 32'hFFFFFFFF;
    beat(1, 1'b1, 1'b0); beat(1, 1'b1, 1'b0); beat(1, 1'b1, 1'b0);
    reset_n = 1'b0;
    #3 reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (sel_valid !== 1'b0 || lit_ready !== 1'b1)
        $display("FAIL rst_mid cyc=%0d got valid=%0b ready=%0b exp 0/1", c, sel_valid, lit_ready);
      else pass_cnt++;
    end
    beat(2, 1'b1, 1'b1);
    wait_valid(got);
    total_cnt++; if (got !== 1'b1 || selected !== 2'd0 || break_value !== 5'd2)
      $display("FAIL rst_restart got sel=%0d brk=%0d exp sel=0 brk=2 valid=%0b", selected, break_value, got); else pass_cnt++;
    take_result;
  endtask

  initial begin
    test_reset;
    test_freebie;
    test_greedy;
    test_noise;
    test_short_and_empty;
    test_backpressure;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
